// File: rtl/poly_modaddsub_stream_if.sv
// ---------------------------------------------------------------------------
// poly_modaddsub_stream_if
// Bundles the coefficient stream of poly_modaddsub_stream.
//   q, op          : modulus and add/sub select, sampled on the first beat
//   in_valid/ready : input handshake carrying operand pair a, b
//   out_valid/ready: output handshake carrying c, out_idx, out_last
//   busy, done     : polynomial-in-progress level and completion pulse
// master = stream producer/consumer (testbench or upstream logic),
// slave  = the engine itself.
// ---------------------------------------------------------------------------
interface poly_modaddsub_stream_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_COEFF    = 256,
  parameter int IDX_W      = $clog2(N_COEFF)
);
  logic [DATA_WIDTH-1:0] q;
  logic                  op;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] c;
  logic [IDX_W-1:0]      out_idx;
  logic                  out_last;
  logic                  busy;
  logic                  done;

  modport master (
    output q, op, in_valid, a, b, out_ready,
    input  in_ready, out_valid, c, out_idx, out_last, busy, done
  );

  modport slave (
    input  q, op, in_valid, a, b, out_ready,
    output in_ready, out_valid, c, out_idx, out_last, busy, done
  );
endinterface

// File: rtl/poly_modaddsub_stream.sv
// ---------------------------------------------------------------------------
// poly_modaddsub_stream
// Streaming modular add/subtract for polynomial coefficients: c = (a +/- b)
// mod q, one coefficient pair per cycle, two registered pipeline stages.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : poly_modaddsub_stream_if.slave (q, op, in_valid/in_ready, a, b,
//           out_valid/out_ready, c, out_idx, out_last, busy, done)
// q and op are captured on the first beat of each polynomial and held for
// all N_COEFF beats; the coefficient index travels alongside the data.
// ---------------------------------------------------------------------------
module poly_modaddsub_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int N_COEFF    = 256,
  parameter int IDX_W      = $clog2(N_COEFF)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  poly_modaddsub_stream_if.slave  bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COEFF - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_r;
  state_t state_nx;

  // polynomial-wide context
  logic [IDX_W-1:0]      in_idx_r;
  logic [DATA_WIDTH-1:0] q_r;
  logic                  op_r;

  // stage 1: raw sum/difference plus correction flag
  logic                  s1_valid_r;
  logic [DATA_WIDTH-1:0] s1_val_r;
  logic                  s1_flag_r;
  logic [IDX_W-1:0]      s1_idx_r;

  // stage 2: fully reduced result, drives the output port directly
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] c_r;
  logic [IDX_W-1:0]      out_idx_r;
  logic                  out_last_r;
  logic                  done_r;

  logic                  stall_s;
  logic                  in_ready_s;
  logic                  in_ready_g_s;
  logic                  accept_s;
  logic                  fin_s;
  logic [DATA_WIDTH-1:0] eff_q_s;
  logic                  eff_op_s;
  logic [IDX_W-1:0]      beat_idx_s;
  logic [DATA_WIDTH:0]   s1_val_s;
  logic                  s1_flag_s;
  logic [DATA_WIDTH-1:0] s2_c_s;

  // Output stage is full and downstream refuses it: freeze both stages.
  assign stall_s  = out_valid_r && !bus.out_ready;
  // Final coefficient leaves the block on this edge.
  assign fin_s    = out_valid_r && bus.out_ready && out_last_r;

  // Ready is forced low while reset is asserted, since IDLE alone would
  // otherwise advertise readiness during reset.
  assign in_ready_g_s = in_ready_s && rst_n;
  assign accept_s     = bus.in_valid && in_ready_g_s;

  // FSM next-state and input readiness
  always_comb begin
    state_nx   = state_r;
    in_ready_s = 1'b0;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (bus.in_valid) begin
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        in_ready_s = !stall_s;
        if (accept_s && (in_idx_r == LAST_IDX)) begin
          state_nx = DRAIN;
        end else begin
          state_nx = RUN;
        end
      end
      DRAIN: begin
        in_ready_s = 1'b0;
        if (fin_s) begin
          state_nx = IDLE;
        end else begin
          state_nx = DRAIN;
        end
      end
      default: begin
        in_ready_s = 1'b0;
        state_nx   = IDLE;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Stage-1 arithmetic. On the first beat q_r/op_r are not yet loaded, so
  // the live port values are used for that beat only.
  always_comb begin
    if (state_r == IDLE) begin
      eff_q_s    = bus.q;
      eff_op_s   = bus.op;
      beat_idx_s = IDX_ZERO;
    end else begin
      eff_q_s    = q_r;
      eff_op_s   = op_r;
      beat_idx_s = in_idx_r;
    end
    if (eff_op_s) begin
      s1_val_s  = {1'b0, bus.a} - {1'b0, bus.b};
      s1_flag_s = (bus.a < bus.b);
    end else begin
      s1_val_s  = {1'b0, bus.a} + {1'b0, bus.b};
      s1_flag_s = (s1_val_s >= {1'b0, eff_q_s});
    end
  end

  // Stage-2 correction. Only the low DATA_WIDTH bits survive, and modular
  // wrap at 2^DATA_WIDTH gives the exact result whenever a, b < q.
  always_comb begin
    if (s1_flag_r) begin
      if (op_r) begin
        s2_c_s = s1_val_r + q_r;
      end else begin
        s2_c_s = s1_val_r - q_r;
      end
    end else begin
      s2_c_s = s1_val_r;
    end
  end

  // Polynomial context: latch q/op on the first beat, count accepted beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_idx_r <= IDX_ZERO;
      q_r      <= {DATA_WIDTH{1'b0}};
      op_r     <= 1'b0;
    end else if (accept_s) begin
      if (state_r == IDLE) begin
        q_r      <= bus.q;
        op_r     <= bus.op;
        in_idx_r <= IDX_ONE;
      end else begin
        in_idx_r <= in_idx_r + IDX_ONE;
      end
    end
  end

  // Stage-1 register: raw result, flag and index of the accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_val_r   <= {DATA_WIDTH{1'b0}};
      s1_flag_r  <= 1'b0;
      s1_idx_r   <= IDX_ZERO;
    end else if (!stall_s) begin
      s1_valid_r <= accept_s;
      if (accept_s) begin
        s1_val_r  <= s1_val_s[DATA_WIDTH-1:0];
        s1_flag_r <= s1_flag_s;
        s1_idx_r  <= beat_idx_s;
      end
    end
  end

  // Stage-2 register: reduced result presented on the output handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      c_r         <= {DATA_WIDTH{1'b0}};
      out_idx_r   <= IDX_ZERO;
      out_last_r  <= 1'b0;
    end else if (!stall_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        c_r        <= s2_c_s;
        out_idx_r  <= s1_idx_r;
        out_last_r <= (s1_idx_r == LAST_IDX);
      end
    end
  end

  // Completion pulse, one cycle after the last coefficient is taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
    end else begin
      done_r <= (state_r == DRAIN) && fin_s;
    end
  end

  assign bus.in_ready  = in_ready_g_s;
  assign bus.out_valid = out_valid_r;
  assign bus.c         = c_r;
  assign bus.out_idx   = out_idx_r;
  assign bus.out_last  = out_last_r;
  assign bus.busy      = (state_r != IDLE);
  assign bus.done      = done_r;

endmodule

// File: doc/poly_modaddsub_stream.md
Name: poly_modaddsub_stream

Overview:
- Streaming modular add/subtract engine for polynomial coefficient arithmetic in the FHE datapath.
- Accepts one coefficient pair per cycle over a valid/ready handshake and returns (a ± b) mod q through a 2-stage pipeline.
- Tracks polynomial boundaries (N_COEFF coefficients per polynomial), flags the last coefficient and pulses done.
- Generalises the combinational 16-bit modular adder: parameterised width and degree, add/sub mode, backpressure, and a fully reduced DATA_WIDTH-bit result.

Parameters:
- DATA_WIDTH, 16, coefficient and modulus width in bits.
- N_COEFF, 256, coefficients per polynomial; must be ≥2.
- IDX_W, $clog2(N_COEFF), coefficient index width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- q  input  DATA_WIDTH  modulus; sampled on the first coefficient of each polynomial.
- op  input  1  0 = add, 1 = subtract; sampled with q.
- in_valid  input  1  a/b pair valid.
- in_ready  output  1  block accepts the pair this cycle.
- a  input  DATA_WIDTH  coefficient of operand A; the caller guarantees a < q.
- b  input  DATA_WIDTH  coefficient of operand B; the caller guarantees b < q.
- out_valid  output  1  c valid.
- out_ready  input  1  downstream accepts c.
- c  output  DATA_WIDTH  result; always < q.
- out_idx  output  IDX_W  coefficient index of c.
- out_last  output  1  c is coefficient N_COEFF-1.
- busy  output  1  a polynomial is in progress (state ≠ IDLE).
- done  output  1  one-cycle pulse: the last coefficient has completed its output handshake.

Behaviour:
- Handshakes:
  - An input beat transfers when in_valid && in_ready.
  - An output beat transfers when out_valid && out_ready.
  - out_valid, c, out_idx and out_last hold stable while out_valid && !out_ready.
- Pipeline stall and flow:
  - stall = s2_valid && !out_ready. While stalled, neither stage advances.
  - Stage 1 (S1) advances into S2 whenever S2 is free or draining.
  - No bubbles when the pipeline is not stalled; one beat per cycle throughput.
- Latency: an input accepted in cycle t produces out_valid in cycle t+2 when unstalled.
- S1 (registered):
  - add: sum = a + b at DATA_WIDTH+1 bits; flag = (sum ≥ q).
  - sub: diff = a − b at DATA_WIDTH+1 bits; flag = (a < b).
- S2 (registered):
  - add: c = flag ? sum − q : sum.
  - sub: c = flag ? diff + q : diff.
  - c is truncated to DATA_WIDTH bits and is exact when a, b < q.
- FSM states:
  - IDLE:
    - in_ready = 1.
    - The first accepted beat latches q_r and op_r, sets in_idx = 1 and moves to RUN.
  - RUN:
    - in_ready = !stall.
    - Each accepted beat increments in_idx.
    - Accepting the beat with in_idx == N_COEFF-1 moves to DRAIN.
  - DRAIN:
    - in_ready = 0.
    - When the out_last beat handshakes: done = 1 for one cycle, go to IDLE.
- In-flight control:
  - q_r and op_r apply to every beat of the polynomial.
  - Changes to q/op during RUN or DRAIN are ignored.
  - The index travels with the data through both stages; out_last = (out_idx == N_COEFF-1).
- Idle behaviour: in_valid low in RUN simply inserts bubbles; the index does not advance.
- Back-to-back polynomials: the next polynomial may start in the cycle after done, once the FSM is back in IDLE.
- Reset (asynchronous, any time including mid-polynomial):
  - State = IDLE; pipeline valids, counters, q_r and op_r cleared.
  - out_valid = 0, c = 0, out_idx = 0, out_last = 0, busy = 0, done = 0.
  - in_ready = 0 while rst_n is low; in_ready = 1 from the first cycle after release.
  - Partial polynomials are discarded.
- Out-of-contract inputs: a or b ≥ q produce an undefined value but must not disturb FSM or counters.

Test Plan:
- N_COEFF=8, q=12289, add, a=12000, b=500, out_ready=1 -> c=211 two cycles after accept; a=12288, b=1 -> c=0; a=5, b=7 -> c=12.
- Subtract, q=12289: a=3, b=10 -> c=12282; a=10, b=10 -> c=0; a=12288, b=0 -> c=12288.
- Full polynomial, 8 consecutive beats, a=i, b=i -> c=2i; out_idx 0..7; out_last only on idx 7; done pulses once in the cycle after the idx-7 output handshake; busy high from the first accept until done.
- Backpressure: out_ready low for 3 cycles mid-stream -> c/out_idx held, in_ready low while stalled, no beat lost or duplicated, ordering preserved.
- q and op changed mid-polynomial (q=7681, op=1 at beat 4) -> all 8 results still use q=12289 with add; the next polynomial uses the new values.
- rst_n pulsed low at beat 5 -> all outputs go to 0 immediately; after release in_ready=1, a new 8-beat polynomial completes normally with indices restarting at 0.
